display_scan_ctrl: RTL
======================

# display_scan_ctrl

Sequencer for the 4-digit multiplexed 7-segment display of the clock. It time-slots the four digit patterns onto the shared segment bus and drives the one-hot anode enables. Each slot starts with a blanking interval to suppress ghosting, then an active interval with PWM brightness and per-digit blink. It sits between the time/alarm formatting logic, which supplies four segment patterns, and the board's display pins. It replaces free-running digit selection with a controlled, glitch-free scan.

## Interface
- DIGIT_TICKS, 250000, Clock cycles per digit slot, blank plus active; must be greater than BLANK_TICKS.
- BLANK_TICKS, 2500, blanking cycles at the start of each slot; must be at least 1.
- BLINK_TICKS, 25000000, half-period of the blink phase in Clock cycles.

Ports:
- Clock, in, 1: system clock, rising edge.
- Reset_n, in, 1: reset, asynchronous, active-low.
- seg0, seg1, seg2, seg3, in, 7 each: segment pattern for digit 0–3, active-low (0 = segment lit).
- enable, in, 1: 1 = scan runs; 0 = display dark and scan parked.
- brightness, in, 3: PWM duty within the active interval; 7 = full on.
- blink_mask, in, 4: bit i = 1 makes digit i blink.
- anode, out, 4: digit enables, active-low one-hot (4'b1111 = all off).
- segments, out, 7: active-low segment bus.
- digit_sel, out, 2: index of the current slot.
- slot_start, out, 1: one-cycle pulse on the first cycle of each slot.

## Operation
- All outputs are registered. Reset values: anode=4'b1111, segments=7'b1111111, digit_sel=0, slot_start=0, FSM=IDLE, blink phase=visible, all counters 0.
- FSM states: IDLE, BLANK, ACTIVE.
- IDLE: anode and segments are off. When enable=1, go to BLANK with digit_sel=0 and pulse slot_start.
- BLANK: lasts exactly BLANK_TICKS cycles. Anode is off and segments=7'b1111111. Then go to ACTIVE.
- On entry to ACTIVE, capture the following for the whole slot: seg[digit_sel], brightness, blink_mask[digit_sel], and the blink phase.
- ACTIVE: lasts exactly DIGIT_TICKS−BLANK_TICKS cycles.
  - segments = the captured pattern.
  - anode[digit_sel] is low on active cycle k (k from 0) iff (k mod 8) ≤ brightness and the digit is not blink-suppressed.
  - At the end of ACTIVE, digit_sel increments mod 4 (3→0), the FSM goes to BLANK, and slot_start pulses.
- Blink suppression: the captured blink_mask bit is 1 and the captured phase is "hidden". In that case anode stays high and segments=7'b1111111 for the whole slot.
- Blink counter: free-running whenever Reset_n is high, independent of enable. It toggles the phase every BLINK_TICKS cycles and starts in "visible".
- enable=0 in any state: on the next edge, go to IDLE, anode=4'b1111, segments=7'b1111111, digit_sel=0, slot counter cleared. Re-enable restarts at digit 0 with a BLANK interval.
- Input changes in mid-slot have no effect until the next ACTIVE entry.
- At most one anode bit is ever low. anode is never low during BLANK or IDLE.

## Timing
- Slot = DIGIT_TICKS cycles exactly. Frame = 4·DIGIT_TICKS cycles. Defaults at 50 MHz: 5 ms slot, 50 Hz frame.
- enable rising to first slot_start: 1 cycle. The first anode-low cycle follows BLANK_TICKS cycles after slot_start.
- slot_start, the digit_sel change, and the BLANK-entry blanking all occur on the same edge.
- Reset_n assertion mid-slot immediately forces the reset values, asynchronously. After deassertion, the block waits in IDLE for enable.
- Counter widths are sized by $clog2 of the parameters. No counter wraps except the 3-bit PWM phase and digit_sel.

## Test plan
- Parameters DIGIT_TICKS=10, BLANK_TICKS=2, BLINK_TICKS=100 apply to all scenarios.
- Basic scan: enable=1, brightness=7, seg0..3 = 7'h01/7'h02/7'h04/7'h08.
  - Expected: slot_start every 10 cycles; anode 1110, 1101, 1011, 0111 in turn, each low for exactly 8 cycles after 2 blank cycles.
  - Expected: segments match the slot digit during ACTIVE and are 7'h7F during BLANK.
- PWM: brightness=0.
  - Expected: anode low only on active cycles k=0 of each 8-cycle group, i.e. 1 low cycle per slot. Repeat with brightness=3: 4 low cycles per slot.
- Blink: blink_mask=4'b0100.
  - Expected: digit 2 is dark for every slot whose ACTIVE entry falls in a hidden phase (100-cycle windows). Digits 0, 1 and 3 are unaffected.
- Mid-slot changes: change seg1 and brightness during digit 1's ACTIVE.
  - Expected: outputs unchanged until the next visit of digit 1.
- Enable drop: deassert enable during the active interval of digit 2.
  - Expected: next edge gives anode=1111, digit_sel=0.
  - Expected: on re-enable, slot_start pulses after 1 cycle and the scan restarts at digit 0.
- Async reset: pulse Reset_n low mid-ACTIVE between clock edges.
  - Expected: outputs go to reset values immediately. The scan waits for enable, and the blink phase restarts as visible.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan sequencer: per-slot blanking, then an
// active interval with 3-bit PWM brightness and per-digit blink.

module scan_lane #(
  parameter int IDX = 0
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       lit,
  input  logic [1:0] sel,
  output logic       anode_n
);
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) anode_n <= 1'b1;
    else          anode_n <= ~(lit && (sel == 2'(IDX)));
endmodule

module display_scan_ctrl #(
  parameter int DIGIT_TICKS = 250000,
  parameter int BLANK_TICKS = 2500,
  parameter int BLINK_TICKS = 25000000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic       enable,
  input  logic [2:0] brightness,
  input  logic [3:0] blink_mask,
  output logic [3:0] anode,
  output logic [6:0] segments,
  output logic [1:0] digit_sel,
  output logic       slot_start
);
  localparam int ACTIVE_TICKS = DIGIT_TICKS - BLANK_TICKS;
  localparam int CW = $clog2(DIGIT_TICKS);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] ACT_LAST   = CW'(ACTIVE_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] bright;
    logic       blink;
    logic       hidden;
  } cap_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      pwm, pwm_nxt;
  logic [1:0]      dsel_nxt;
  logic            start_nxt;
  logic            enter_act;
  cap_t            cap, cap_live, cap_nxt;
  logic [BW-1:0]   bcnt;
  logic            hidden;
  logic            lit_nxt;
  logic [6:0]      seg_nxt;
  logic [3:0][6:0] seg_arr;

  assign seg_arr = {seg3, seg2, seg1, seg0};

  // Blink phase runs from reset regardless of enable, so blinking stays
  // in step with wall time rather than with scan restarts.
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      bcnt   <= '0;
      hidden <= 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt   <= '0;
      hidden <= ~hidden;
    end else begin
      bcnt   <= bcnt + 1'b1;
    end

  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pwm        <= '0;
      digit_sel  <= 2'd0;
      slot_start <= 1'b0;
      segments   <= 7'h7F;
      cap        <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pwm        <= pwm_nxt;
      digit_sel  <= dsel_nxt;
      slot_start <= start_nxt;
      segments   <= seg_nxt;
      cap        <= cap_nxt;
    end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pwm_nxt   = pwm;
    dsel_nxt  = digit_sel;
    start_nxt = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pwm_nxt   = '0;
      dsel_nxt  = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          dsel_nxt  = 2'd0;
          start_nxt = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = ACTIVE;
            cnt_nxt   = '0;
            pwm_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt == ACT_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            dsel_nxt  = digit_sel + 2'd1;
            start_nxt = 1'b1;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            pwm_nxt   = pwm + 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          dsel_nxt  = 2'd0;
        end
      endcase
    end
  end

  // Inputs are sampled only on the BLANK->ACTIVE edge; the first active
  // cycle already needs them, so the live values bypass the capture reg.
  assign enter_act = (state == BLANK) && (state_nxt == ACTIVE);
  assign cap_live  = '{seg:    seg_arr[digit_sel],
                       bright: brightness,
                       blink:  blink_mask[digit_sel],
                       hidden: hidden};
  assign cap_nxt   = enter_act ? cap_live : cap;

  always_comb begin
    lit_nxt = 1'b0;
    seg_nxt = 7'h7F;
    if (state_nxt == ACTIVE && !(cap_nxt.blink && cap_nxt.hidden)) begin
      seg_nxt = cap_nxt.seg;
      lit_nxt = (pwm_nxt <= cap_nxt.bright);
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    scan_lane #(.IDX(i)) u_lane (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .lit     (lit_nxt),
      .sel     (dsel_nxt),
      .anode_n (anode[i])
    );
  end
endmodule
